// File: rtl/ks_adder_pipe_if.sv
// Operation/result bundle for ks_adder_pipe.
// Signal names follow the adder's own port view (i_ in, o_ out).
interface ks_adder_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_c0;
  logic             i_sub;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic [TAG_W-1:0] o_tag;

  modport master (
    output i_valid,
    output i_a,
    output i_b,
    output i_c0,
    output i_sub,
    output i_tag,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_sum,
    input  o_cout,
    input  o_ovf,
    input  o_tag
  );

  modport slave (
    input  i_valid,
    input  i_a,
    input  i_b,
    input  i_c0,
    input  i_sub,
    input  i_tag,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_sum,
    output o_cout,
    output o_ovf,
    output o_tag
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/sub with carry-in, overflow flag,
// tag sideband and a bubble-collapsing valid/ready pipeline.
module ks_adder_pipe #(
  parameter int WIDTH      = 32,
  parameter int REG_STRIDE = 1,
  parameter int TAG_W      = 6
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ks_adder_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NR =
    (LEVELS + REG_STRIDE - 1) / REG_STRIDE;
  localparam int NS = NR + 2;
  localparam int OS = NS - 1;

  logic [NS-1:0]    w_v;
  logic [NS-1:0]    w_ld;
  logic [WIDTH-1:0] w_G   [NR+1];
  logic [WIDTH-1:0] w_P   [NR];
  logic [WIDTH-1:0] w_pv  [NR+1];
  logic             w_c   [NR+1];
  logic [TAG_W-1:0] w_tag [NR+1];

  // A stage may load if any stage from it onward is empty
  // or the output drains: equivalent to the ripple of
  // "empty or successor loads", without a combinational chain.
  for (genvar s = 0; s < NS; s++) begin : g_ld
    assign w_ld[s] = bus.i_ready | ~(&w_v[OS:s]);
  end

  assign bus.o_ready = w_ld[0];

  logic             r0_v;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r0_c;
  logic [TAG_W-1:0] r0_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r0_v   <= 1'b0;
      r0_a   <= '0;
      r0_b   <= '0;
      r0_c   <= 1'b0;
      r0_tag <= '0;
    end else if (w_ld[0]) begin
      r0_v   <= bus.i_valid;
      r0_a   <= bus.i_a;
      r0_b   <= bus.i_sub ? ~bus.i_b : bus.i_b;
      r0_c   <= bus.i_sub | bus.i_c0;
      r0_tag <= bus.i_tag;
    end
  end

  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;

  assign w_p0 = r0_a ^ r0_b;
  assign w_g0 = r0_a & r0_b;

  // Carry-in enters as g[-1] through a grey cell on bit 0.
  assign w_v[0]   = r0_v;
  assign w_G[0]   = {w_g0[WIDTH-1:1],
                     w_g0[0] | (w_p0[0] & r0_c)};
  assign w_P[0]   = w_p0;
  assign w_pv[0]  = w_p0;
  assign w_c[0]   = r0_c;
  assign w_tag[0] = r0_tag;

  for (genvar r = 1; r <= NR; r++) begin : g_pre
    localparam int LO = (r - 1) * REG_STRIDE;
    localparam int HI = (r * REG_STRIDE < LEVELS) ?
                        r * REG_STRIDE : LEVELS;

    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic             r_v;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic             r_c;
    logic [TAG_W-1:0] r_tag;

    // High-to-low walk keeps bit i-d at its previous level.
    always_comb begin
      w_gn = w_G[r-1];
      w_pn = w_P[r-1];
      for (int k = LO; k < HI; k++) begin
        for (int i = WIDTH - 1; i >= (1 << k); i--) begin
          w_gn[i] = w_gn[i] |
                    (w_pn[i] & w_gn[i - (1 << k)]);
          w_pn[i] = w_pn[i] & w_pn[i - (1 << k)];
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_v   <= 1'b0;
        r_g   <= '0;
        r_p   <= '0;
        r_c   <= 1'b0;
        r_tag <= '0;
      end else if (w_ld[r]) begin
        r_v   <= w_v[r-1];
        r_g   <= w_gn;
        r_p   <= w_pv[r-1];
        r_c   <= w_c[r-1];
        r_tag <= w_tag[r-1];
      end
    end

    assign w_v[r]   = r_v;
    assign w_G[r]   = r_g;
    assign w_pv[r]  = r_p;
    assign w_c[r]   = r_c;
    assign w_tag[r] = r_tag;

    // Group propagate is dead after the final prefix level.
    if (r < NR) begin : g_preg
      logic [WIDTH-1:0] r_pg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pg <= '0;
        end else if (w_ld[r]) begin
          r_pg <= w_pn;
        end
      end

      assign w_P[r] = r_pg;
    end
  end

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_carry = {w_G[NR][WIDTH-2:0], w_c[NR]};
  assign w_sum   = w_pv[NR] ^ w_carry;
  assign w_cout  = w_G[NR][WIDTH-1];

  logic             r_ov;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [TAG_W-1:0] r_otag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ov   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_otag <= '0;
    end else if (w_ld[OS]) begin
      r_ov   <= w_v[NR];
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_carry[WIDTH-1] ^ w_cout;
      r_otag <= w_tag[NR];
    end
  end

  assign w_v[OS]     = r_ov;
  assign bus.o_valid = r_ov;
  assign bus.o_sum   = r_sum;
  assign bus.o_cout  = r_cout;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_tag   = r_otag;
endmodule
